// File: rtl/regf_wr_arbiter.sv
// rtl/regf_wr_arbiter.sv - round-robin two-port write scheduler for the 8-entry register file
// Optional grant/conflict statistics counters are enabled by defining REGF_WR_ARB_STATS_EN.
module regf_wr_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 3,
    parameter int DW   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 wr0,
    output logic [AW-1:0]        Addr0,
    output logic [DW-1:0]        Din0,
    output logic                 wr1,
    output logic [AW-1:0]        Addr1,
    output logic [DW-1:0]        Din1,
`ifdef REGF_WR_ARB_STATS_EN
    output logic [15:0]          grant_cnt,
    output logic [15:0]          conflict_cnt,
`endif
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] r_rr_ptr;
    logic          r_wr0, r_wr1;
    logic [AW-1:0] r_addr0, r_addr1;
    logic [DW-1:0] r_din0, r_din1;

    logic [AW-1:0] w_addr [NREQ];
    logic [DW-1:0] w_data [NREQ];
    logic [PW-1:0] w_scan [NREQ];
    logic          w_a_found, w_b_found, w_conflict;
    logic [PW-1:0] w_a_idx, w_b_idx, w_last_idx, w_ptr_nxt;
    logic [NREQ-1:0] w_ready;

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            w_addr[k] = req_addr[k*AW +: AW];
            w_data[k] = req_data[k*DW +: DW];
            w_scan[k] = PW'((int'(r_rr_ptr) + k) % NREQ);
        end
    end

    // Requesters matching port 0's address are skipped so the two ports never collide.
    always_comb begin
        w_a_found  = 1'b0;
        w_b_found  = 1'b0;
        w_conflict = 1'b0;
        w_a_idx    = '0;
        w_b_idx    = '0;
        w_ready    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!rst && req_valid[w_scan[k]]) begin
                if (!w_a_found) begin
                    w_a_found = 1'b1;
                    w_a_idx   = w_scan[k];
                end else if (w_addr[w_scan[k]] == w_addr[w_a_idx]) begin
                    w_conflict = 1'b1;
                end else if (!w_b_found) begin
                    w_b_found = 1'b1;
                    w_b_idx   = w_scan[k];
                end
            end
        end
        if (w_a_found) w_ready[w_a_idx] = 1'b1;
        if (w_b_found) w_ready[w_b_idx] = 1'b1;
    end

    assign w_last_idx = w_b_found ? w_b_idx : w_a_idx;
    assign w_ptr_nxt  = (w_last_idx == PW'(NREQ - 1)) ? '0 : w_last_idx + PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_wr0    <= 1'b0;
            r_wr1    <= 1'b0;
            r_addr0  <= '0;
            r_addr1  <= '0;
            r_din0   <= '0;
            r_din1   <= '0;
        end else begin
            r_wr0 <= w_a_found;
            r_wr1 <= w_b_found;
            if (w_a_found) begin
                r_addr0  <= w_addr[w_a_idx];
                r_din0   <= w_data[w_a_idx];
                r_rr_ptr <= w_ptr_nxt;
            end
            if (w_b_found) begin
                r_addr1 <= w_addr[w_b_idx];
                r_din1  <= w_data[w_b_idx];
            end
        end
    end

`ifdef REGF_WR_ARB_STATS_EN
    logic [15:0] r_grant_cnt, r_conflict_cnt;
    logic [16:0] w_grant_sum;

    assign w_grant_sum = {1'b0, r_grant_cnt} + {15'd0, w_a_found} + {15'd0, w_b_found};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_cnt    <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_grant_cnt <= w_grant_sum[16] ? 16'hFFFF : w_grant_sum[15:0];
            if (w_conflict && r_conflict_cnt != 16'hFFFF)
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign grant_cnt    = r_grant_cnt;
    assign conflict_cnt = r_conflict_cnt;
`endif

    assign req_ready = w_ready;
    assign busy      = |(req_valid & ~w_ready);
    assign wr0       = r_wr0;
    assign Addr0     = r_addr0;
    assign Din0      = r_din0;
    assign wr1       = r_wr1;
    assign Addr1     = r_addr1;
    assign Din1      = r_din1;

endmodule
